dot11_tx_sched: RTL

//  Round-robin transmit scheduler in front of dot11_tx. Arbitrates NUM_REQ frame requesters,

---
 rtl/dot11_tx_sched.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/dot11_tx_sched.sv
// Round-robin transmit scheduler in front of dot11_tx: grants one requester at a time,
// latches its frame descriptor and walks dot11_tx through reset, start, completion and gap.
module dot11_tx_sched #(
    parameter int NUM_REQ      = 2,
    parameter int ADDR_W       = 12,
    parameter int RST_CYCLES   = 4,
    parameter int START_CYCLES = 5,
    parameter int IFS_CYCLES   = 32,
    parameter int TIMEOUT      = 65535
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      en,
    input  logic                      abort,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_base_addr,
    input  logic [NUM_REQ*128-1:0]    req_mask,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [NUM_REQ-1:0]        req_done,
    output logic                      done_err,
    output logic                      busy,
    output logic [15:0]               tx_count,
    output logic                      phy_tx_arest,
    output logic                      phy_tx_start,
    input  logic                      phy_tx_started,
    input  logic                      phy_tx_done,
    output logic [ADDR_W-1:0]         bram_base_addr,
    output logic [127:0]              mask
);

    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_MAX = (RST_CYCLES > START_CYCLES)
                           ? ((RST_CYCLES > IFS_CYCLES) ? RST_CYCLES : IFS_CYCLES)
                           : ((START_CYCLES > IFS_CYCLES) ? START_CYCLES : IFS_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int WD_W    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_START, S_WAIT_ST, S_WAIT_DONE, S_GAP
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic [PTR_W-1:0]     rr_q, rr_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 err_q, err_d;
    logic [15:0]          count_q, count_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic [127:0]         mask_q, mask_d;
    logic                 arest_q, arest_d;
    logic                 start_q, start_d;
    logic                 busy_q, busy_d;

    logic [PTR_W-1:0]     grant_idx;
    logic                 active, in_frame, finish;

    // First pending requester at or after the pointer, wrapping around.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                 input logic [PTR_W-1:0]   ptr);
        logic [PTR_W-1:0] pick;
        logic             found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && v[idx]) begin
                found = 1'b1;
                pick  = PTR_W'(idx);
            end
        end
        return pick;
    endfunction

    assign grant_idx = rr_pick(req_valid, rr_q);

    always_comb begin
        // NOTE: every signal gets its default first so no branch can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        ack_d   = '0;
        done_d  = '0;
        err_d   = 1'b0;
        count_d = count_q;
        base_d  = base_q;
        mask_d  = mask_q;
        finish  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (en && |req_valid) begin
                    ack_d   = NUM_REQ'(1) << grant_idx;
                    owner_d = grant_idx;
                    base_d  = req_base_addr[grant_idx*ADDR_W +: ADDR_W];
                    mask_d  = req_mask[grant_idx*128 +: 128];
                    rr_d    = PTR_W'((int'(grant_idx) + 1) % NUM_REQ);
                    cnt_d   = '0;
                    state_d = S_RST;
                end
            end
            S_RST: begin
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    cnt_d   = '0;
                    wd_d    = '0;
                    state_d = S_START;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_START: begin
                cnt_d = cnt_q + CNT_W'(1);
                wd_d  = wd_q + WD_W'(1);
                if (phy_tx_started) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == CNT_W'(START_CYCLES - 1)) begin
                    state_d = S_WAIT_ST;
                end
            end
            S_WAIT_ST: begin
                wd_d = wd_q + WD_W'(1);
                if (phy_tx_started) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: wd_d = wd_q + WD_W'(1);
            S_GAP: begin
                if (cnt_q == CNT_W'(IFS_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Completion priority: abort, then a real done, then the watchdog.
        active   = (state_q != S_IDLE) && (state_q != S_GAP);
        in_frame = (state_q == S_START) || (state_q == S_WAIT_ST) || (state_q == S_WAIT_DONE);
        if (active && abort) begin
            finish = 1'b1;
            err_d  = 1'b1;
        end else if (in_frame && phy_tx_done) begin
            finish  = 1'b1;
            count_d = count_q + 16'd1;
        end else if (in_frame && (wd_q == WD_W'(TIMEOUT - 1))) begin
            finish = 1'b1;
            err_d  = 1'b1;
        end
        if (finish) begin
            done_d  = NUM_REQ'(1) << owner_q;
            cnt_d   = '0;
            state_d = S_GAP;
        end

        // Outputs are decoded from the next state so the registered copies line up with it.
        arest_d = !((state_d == S_START) || (state_d == S_WAIT_ST) || (state_d == S_WAIT_DONE));
        start_d = (state_d == S_START);
        busy_d  = (state_d != S_IDLE);
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wd_q    <= '0;
            rr_q    <= '0;
            owner_q <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            count_q <= '0;
            base_q  <= '0;
            mask_q  <= '0;
            arest_q <= 1'b1;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            err_q   <= err_d;
            count_q <= count_d;
            base_q  <= base_d;
            mask_q  <= mask_d;
            arest_q <= arest_d;
            start_q <= start_d;
            busy_q  <= busy_d;
        end
    end

    assign req_ack        = ack_q;
    assign req_done       = done_q;
    assign done_err       = err_q;
    assign busy           = busy_q;
    assign tx_count       = count_q;
    assign phy_tx_arest   = arest_q;
    assign phy_tx_start   = start_q;
    assign bram_base_addr = base_q;
    assign mask           = mask_q;

endmodule
